// File: rtl/gelato_simt_stack.sv
// Per-warp SIMT reconvergence stack feeding fetch pc/mask; GELATO_SIMT_STACK_PERF_EN adds the divergence counter.
// Latency: sel_* combinational from stack tops, updates land on the next clk edge.
// Backpressure: rdy low freezes all state; a divergent push without room is dropped and raises ovf_err.
module gelato_simt_stack #(
  parameter int WARP_NUM    = 4,
  parameter int THREAD_NUM  = 32,
  parameter int PC_WIDTH    = 32,
  parameter int STACK_DEPTH = 8,
  localparam int WARP_W     = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1,
  localparam int THREAD_W   = $clog2(THREAD_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           init_valid,
  input  logic [PC_WIDTH-1:0]            init_pc,
  input  logic [WARP_W+THREAD_W:0]       init_workers,
  input  logic                           upd_valid,
  input  logic [WARP_W-1:0]              upd_warp,
  input  logic [1:0]                     upd_kind,
  input  logic [PC_WIDTH-1:0]            upd_next_pc,
  input  logic [PC_WIDTH-1:0]            upd_taken_pc,
  input  logic [THREAD_NUM-1:0]          upd_taken,
  input  logic [PC_WIDTH-1:0]            upd_rpc,
  output logic [WARP_NUM-1:0]            sel_valid,
  output logic [WARP_NUM*PC_WIDTH-1:0]   sel_pc,
  output logic [WARP_NUM*THREAD_NUM-1:0] sel_mask,
  output logic                           act_valid,
  output logic [WARP_W-1:0]              act_warp,
  output logic                           ovf_err,
  output logic [31:0]                    div_count
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = $clog2(STACK_DEPTH);

  localparam logic [1:0] K_ADV  = 2'd0;
  localparam logic [1:0] K_BR   = 2'd1;
  localparam logic [1:0] K_EXIT = 2'd2;
  localparam logic [1:0] K_RSV  = 2'd3;

  logic [PC_WIDTH-1:0]   pc_q   [WARP_NUM][STACK_DEPTH];
  logic [THREAD_NUM-1:0] mask_q [WARP_NUM][STACK_DEPTH];
  logic [PC_WIDTH-1:0]   rpc_q  [WARP_NUM][STACK_DEPTH];
  logic [DEPTH_W-1:0]    depth_q[WARP_NUM];

  logic [THREAD_NUM-1:0] init_mask[WARP_NUM];
  int                    n_workers;

  logic [DEPTH_W-1:0]    u_depth;
  logic [IDX_W-1:0]      u_idx, u_idx1, u_idx2;
  logic [PC_WIDTH-1:0]   u_pc, u_rpc, new_pc;
  logic [THREAD_NUM-1:0] u_mask, t_mask, nt_mask;
  logic                  accept, is_branch, diverged, has_space, do_pop;
  logic                  push_ok, step_ok, exit_ok, refuse;

  // Thread t of warp w is live when its global index falls below the worker count.
  always_comb begin
    n_workers = int'(init_workers);
    for (int w = 0; w < WARP_NUM; w++) begin
      init_mask[w] = '0;
      for (int t = 0; t < THREAD_NUM; t++) begin
        init_mask[w][t] = (w * THREAD_NUM + t) < n_workers;
      end
    end
  end

  always_comb begin
    sel_valid = '0;
    sel_pc    = '0;
    sel_mask  = '0;
    for (int w = 0; w < WARP_NUM; w++) begin
      sel_valid[w] = depth_q[w] != '0;
      if (sel_valid[w]) begin
        sel_pc[w*PC_WIDTH +: PC_WIDTH]       = pc_q[w][IDX_W'(depth_q[w] - DEPTH_W'(1))];
        sel_mask[w*THREAD_NUM +: THREAD_NUM] = mask_q[w][IDX_W'(depth_q[w] - DEPTH_W'(1))];
      end
    end
  end

  always_comb begin
    u_depth   = depth_q[upd_warp];
    u_idx     = IDX_W'(u_depth - DEPTH_W'(1));
    u_idx1    = IDX_W'(u_depth);
    u_idx2    = IDX_W'(u_depth + DEPTH_W'(1));
    u_pc      = pc_q[upd_warp][u_idx];
    u_mask    = mask_q[upd_warp][u_idx];
    u_rpc     = rpc_q[upd_warp][u_idx];
    t_mask    = upd_taken & u_mask;
    nt_mask   = u_mask & ~upd_taken;
    accept    = rdy & upd_valid & (u_depth != '0) & (upd_kind != K_RSV);
    is_branch = upd_kind == K_BR;
    diverged  = is_branch & (t_mask != '0) & (t_mask != u_mask);
    has_space = (int'(u_depth) + 2) <= STACK_DEPTH;
    new_pc    = (is_branch & (t_mask == u_mask)) ? upd_taken_pc : upd_next_pc;
    // Only entries above the kernel root carry a real rpc, so depth 1 never pops.
    do_pop    = (new_pc == u_rpc) & (u_depth > DEPTH_W'(1));
    push_ok   = accept & ~init_valid & diverged & has_space;
    refuse    = accept & ~init_valid & diverged & ~has_space;
    step_ok   = accept & ~init_valid & ((upd_kind == K_ADV) | is_branch) & ~diverged;
    exit_ok   = accept & ~init_valid & (upd_kind == K_EXIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WARP_NUM; w++) depth_q[w] <= '0;
      act_valid <= 1'b0;
      act_warp  <= '0;
      ovf_err   <= 1'b0;
    end else if (rdy) begin
      act_valid <= accept;
      if (accept) act_warp <= upd_warp;
      if (init_valid) begin
        for (int w = 0; w < WARP_NUM; w++)
          depth_q[w] <= (init_mask[w] != '0) ? DEPTH_W'(1) : '0;
        ovf_err <= 1'b0;
      end else begin
        if (push_ok)          depth_q[upd_warp] <= u_depth + DEPTH_W'(2);
        if (step_ok & do_pop) depth_q[upd_warp] <= u_depth - DEPTH_W'(1);
        if (exit_ok)          depth_q[upd_warp] <= '0;
        if (refuse)           ovf_err <= 1'b1;
      end
    end
  end

  // Entry storage needs no reset: depth gates every read.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (init_valid) begin
        for (int w = 0; w < WARP_NUM; w++) begin
          pc_q[w][0]   <= init_pc;
          mask_q[w][0] <= init_mask[w];
          rpc_q[w][0]  <= '1;
        end
      end else if (push_ok) begin
        pc_q[upd_warp][u_idx]    <= upd_rpc;
        pc_q[upd_warp][u_idx1]   <= upd_next_pc;
        mask_q[upd_warp][u_idx1] <= nt_mask;
        rpc_q[upd_warp][u_idx1]  <= upd_rpc;
        pc_q[upd_warp][u_idx2]   <= upd_taken_pc;
        mask_q[upd_warp][u_idx2] <= t_mask;
        rpc_q[upd_warp][u_idx2]  <= upd_rpc;
      end else if (step_ok) begin
        pc_q[upd_warp][u_idx] <= new_pc;
      end
    end
  end

`ifdef GELATO_SIMT_STACK_PERF_EN
  logic [31:0] div_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (rdy) begin
      if (init_valid)                  div_q <= '0;
      else if (push_ok && div_q != '1) div_q <= div_q + 32'd1;
    end
  end

  assign div_count = div_q;
`else
  assign div_count = '0;
`endif

endmodule
